// File: rtl/ld_align_unit_if.sv
// ld_align_unit_if: handshake bundle for the MEM-stage load alignment unit.
//   req_*      load request from MEM (valid/ready, funct3, byte address)
//   mem_req_*  word-aligned read request towards data memory (valid/ready, address)
//   mem_rsp_*  read data returned by memory (single-cycle valid pulse)
//   out_*      aligned/extended result towards WB (valid/ready, data, error code)
// Modports: slave = the alignment unit, master = the surrounding pipeline/memory.
`timescale 1ns/1ps
interface ld_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic [1:0]        out_err;

  modport slave (
    input  req_valid, req_func3, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
    output req_ready, mem_req_valid, mem_req_addr, out_valid, out_data, out_err
  );

  modport master (
    output req_valid, req_func3, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
    input  req_ready, mem_req_valid, mem_req_addr, out_valid, out_data, out_err
  );
endinterface

// File: rtl/ld_align_unit.sv
// ld_align_unit: sequential load-data path between MEM and WB. Accepts a load
// (funct3 + byte address), reads the aligned word(s) from data memory, then
// shifts, size-extracts and sign/zero-extends the result to XLEN.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  ld_align_unit_if.slave (request, memory request/response, result)
// Parameters: XLEN (32 or 64), ADDR_W (byte address width).
// Build option: LD_MISALIGN_SPLIT_EN - when defined, loads that cross a word
//   boundary are served with two memory beats; otherwise they return out_err=10
//   with out_data=0 and no memory access.
`timescale 1ns/1ps
module ld_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  ld_align_unit_if.slave bus
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, A0, W0, A1, W1, RESP} state_t;

  state_t            state;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_ready_r;
  logic              mem_req_valid_r;
  logic [ADDR_W-1:0] mem_req_addr_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   out_data_r;
  logic [1:0]        out_err_r;
`ifdef LD_MISALIGN_SPLIT_EN
  logic [XLEN-1:0]   word0_q;
`endif

  assign bus.req_ready     = req_ready_r;
  assign bus.mem_req_valid = mem_req_valid_r;
  assign bus.mem_req_addr  = mem_req_addr_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_data      = out_data_r;
  assign bus.out_err       = out_err_r;

  // LD/LWU only exist on a 64-bit datapath; 111 is never a load.
  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
  endfunction

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  endfunction

  // Access spills into the next word when offset + size exceeds the word.
  function automatic logic crosses(input logic [OFFW-1:0] off, input logic [2:0] f3);
    return (int'(off) + (1 << f3[1:0])) > BYTES;
  endfunction

  // Shift the word pair down to the addressed byte, then size and extend.
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] pair,
                                               input logic [OFFW-1:0]   off,
                                               input logic [2:0]        f3);
    logic [XLEN-1:0]    w;
    logic [XLEN-1:0]    r;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] wd;
    w  = XLEN'(pair >> {off, 3'b000});
    b  = w[7:0];
    h  = w[15:0];
    wd = w[31:0];
    case (f3[1:0])
      2'b00: begin
        if (f3[2]) r = XLEN'(w[7:0]);
        else       r = XLEN'(b);
      end
      2'b01: begin
        if (f3[2]) r = XLEN'(w[15:0]);
        else       r = XLEN'(h);
      end
      2'b10: begin
        if (f3[2]) r = XLEN'(w[31:0]);
        else       r = XLEN'(wd);
      end
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      f3_q            <= '0;
      addr_q          <= '0;
      req_ready_r     <= 1'b1;
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= '0;
      out_valid_r     <= 1'b0;
      out_data_r      <= '0;
      out_err_r       <= 2'b00;
`ifdef LD_MISALIGN_SPLIT_EN
      word0_q         <= '0;
`endif
    end else begin
      case (state)
        // Accept a request; reject illegal or (when not splitting) word-crossing loads here.
        IDLE: begin
          if (bus.req_valid) begin
            f3_q        <= bus.req_func3;
            addr_q      <= bus.req_addr;
            req_ready_r <= 1'b0;
            if (is_illegal(bus.req_func3)) begin
              state       <= RESP;
              out_valid_r <= 1'b1;
              out_data_r  <= '0;
              out_err_r   <= 2'b01;
`ifndef LD_MISALIGN_SPLIT_EN
            end else if (crosses(bus.req_addr[OFFW-1:0], bus.req_func3)) begin
              state       <= RESP;
              out_valid_r <= 1'b1;
              out_data_r  <= '0;
              out_err_r   <= 2'b10;
`endif
            end else begin
              state           <= A0;
              mem_req_valid_r <= 1'b1;
              mem_req_addr_r  <= align(bus.req_addr);
            end
          end
        end
        // First word request
        A0: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            state           <= W0;
          end
        end
        // First word response
        W0: begin
          if (bus.mem_rsp_valid) begin
`ifdef LD_MISALIGN_SPLIT_EN
            if (crosses(addr_q[OFFW-1:0], f3_q)) begin
              word0_q         <= bus.mem_rsp_data;
              state           <= A1;
              mem_req_valid_r <= 1'b1;
              mem_req_addr_r  <= mem_req_addr_r + ADDR_W'(BYTES);
            end else begin
              state       <= RESP;
              out_valid_r <= 1'b1;
              out_data_r  <= extract({{XLEN{1'b0}}, bus.mem_rsp_data}, addr_q[OFFW-1:0], f3_q);
              out_err_r   <= 2'b00;
            end
`else
            state       <= RESP;
            out_valid_r <= 1'b1;
            out_data_r  <= extract({{XLEN{1'b0}}, bus.mem_rsp_data}, addr_q[OFFW-1:0], f3_q);
            out_err_r   <= 2'b00;
`endif
          end
        end
`ifdef LD_MISALIGN_SPLIT_EN
        // Second word request (next word, address wraps)
        A1: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            state           <= W1;
          end
        end
        // Second word response; merge with the held first word
        W1: begin
          if (bus.mem_rsp_valid) begin
            state       <= RESP;
            out_valid_r <= 1'b1;
            out_data_r  <= extract({bus.mem_rsp_data, word0_q}, addr_q[OFFW-1:0], f3_q);
            out_err_r   <= 2'b00;
          end
        end
`endif
        // Hold result until WB takes it; req_ready returns on the following cycle.
        RESP: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ld_align_unit.sv
// tb_ld_align_unit: directed bench for ld_align_unit at XLEN=32 and XLEN=64,
// with a small word-addressed memory model per instance. Expected results
// depend on whether LD_MISALIGN_SPLIT_EN is defined for the build.
`timescale 1ns/1ps
module tb_ld_align_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ld_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus32 ();
  ld_align_unit_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

  ld_align_unit #(.XLEN(32), .ADDR_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  ld_align_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory models: accept on valid&ready, respond in the following cycle unless muted.
  logic [31:0] m32 [logic [31:0]];
  logic [63:0] m64 [logic [31:0]];
  logic [31:0] alog32[$];
  logic [31:0] alog64[$];
  bit          mute32, pend32, seen32;
  bit          pend64, seen64;
  logic [31:0] paddr32, paddr64;

  initial begin
    bus32.mem_rsp_valid = 1'b0;
    bus32.mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      if (bus32.mem_req_valid) seen32 = 1'b1;
      if (bus32.mem_req_valid && bus32.mem_req_ready) begin
        pend32  = 1'b1;
        paddr32 = bus32.mem_req_addr;
        alog32.push_back(bus32.mem_req_addr);
      end
      #1;
      if (pend32 && !mute32) begin
        bus32.mem_rsp_valid = 1'b1;
        bus32.mem_rsp_data  = m32.exists(paddr32) ? m32[paddr32] : 32'hDEAD_BEEF;
        pend32 = 1'b0;
      end else begin
        bus32.mem_rsp_valid = 1'b0;
        bus32.mem_rsp_data  = '0;
      end
    end
  end

  initial begin
    bus64.mem_rsp_valid = 1'b0;
    bus64.mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      if (bus64.mem_req_valid) seen64 = 1'b1;
      if (bus64.mem_req_valid && bus64.mem_req_ready) begin
        pend64  = 1'b1;
        paddr64 = bus64.mem_req_addr;
        alog64.push_back(bus64.mem_req_addr);
      end
      #1;
      if (pend64) begin
        bus64.mem_rsp_valid = 1'b1;
        bus64.mem_rsp_data  = m64.exists(paddr64) ? m64[paddr64] : 64'hDEAD_BEEF_DEAD_BEEF;
        pend64 = 1'b0;
      end else begin
        bus64.mem_rsp_valid = 1'b0;
        bus64.mem_rsp_data  = '0;
      end
    end
  end

  function automatic logic [31:0] log_at(input bit w64, input int i);
    if (w64) return (i < alog64.size()) ? alog64[i] : 32'hFFFF_FFFF;
    return (i < alog32.size()) ? alog32[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic ov(input bit w64);
    return w64 ? bus64.out_valid : bus32.out_valid;
  endfunction

  function automatic logic [63:0] od(input bit w64);
    return w64 ? bus64.out_data : {32'h0, bus32.out_data};
  endfunction

  function automatic logic rr(input bit w64);
    return w64 ? bus64.req_ready : bus32.req_ready;
  endfunction

  // Issue one load, wait (bounded) for the result, hold out_ready low for 'hold' cycles.
  task automatic do_load(input bit w64, input logic [2:0] f3, input logic [31:0] addr,
                         input int hold, output logic [63:0] data, output logic [1:0] err,
                         output int lat);
    alog32.delete();
    alog64.delete();
    seen32 = 1'b0;
    seen64 = 1'b0;
    if (w64) begin
      bus64.req_func3 = f3; bus64.req_addr = addr; bus64.req_valid = 1'b1;
    end else begin
      bus32.req_func3 = f3; bus32.req_addr = addr; bus32.req_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus32.req_valid = 1'b0;
    bus64.req_valid = 1'b0;
    lat = 0;
    while (!ov(w64) && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", 64'(ov(w64)), 64'd1);
    data = od(w64);
    err  = w64 ? bus64.out_err : bus32.out_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(ov(w64)), 64'd1);
      check("hold_data", od(w64), data);
      check("hold_req_ready", 64'(rr(w64)), 64'd0);
    end
    bus32.out_ready = w64 ? 1'b0 : 1'b1;
    bus64.out_ready = w64;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    bus64.out_ready = 1'b0;
    check("valid_drop", 64'(ov(w64)), 64'd0);
    check("req_ready_back", 64'(rr(w64)), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  e;
    int          lat, lat_al;
    checks = 0; errors = 0;
    clk = 0; rst = 1;
    mute32 = 0;
    bus32.req_valid = 0; bus32.req_func3 = '0; bus32.req_addr = '0;
    bus32.mem_req_ready = 1; bus32.out_ready = 0;
    bus64.req_valid = 0; bus64.req_func3 = '0; bus64.req_addr = '0;
    bus64.mem_req_ready = 1; bus64.out_ready = 0;
    repeat (2) @(posedge clk); #1;

    check("rst_req_ready", 64'(bus32.req_ready), 64'd1);
    check("rst_mem_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    check("rst_mem_req_addr", 64'(bus32.mem_req_addr), 64'd0);
    check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_out_data", 64'(bus32.out_data), 64'd0);
    check("rst_out_err", 64'(bus32.out_err), 64'd0);
    check("rst64_req_ready", 64'(bus64.req_ready), 64'd1);
    rst = 0;
    @(posedge clk); #1;

    // LB with sign bit set in the top byte
    m32[32'h100] = 32'h80FF_1234;
    do_load(0, 3'b000, 32'h103, 0, d, e, lat);
    check("lb_data", d, 64'hFFFF_FF80);
    check("lb_err", 64'(e), 64'd0);
    check("lb_beats", 64'(alog32.size()), 64'd1);
    check("lb_addr", 64'(log_at(0, 0)), 64'h100);
    lat_al = lat;

    // Halfword zero/sign extension, in-word misaligned halfword, aligned word
    m32[32'h100] = 32'hBEEF_0000;
    do_load(0, 3'b101, 32'h102, 0, d, e, lat);
    check("lhu_data", d, 64'h0000_BEEF);
    do_load(0, 3'b001, 32'h102, 0, d, e, lat);
    check("lh_data", d, 64'hFFFF_BEEF);
    do_load(0, 3'b001, 32'h101, 0, d, e, lat);
    check("lh_off1_data", d, 64'hFFFF_EF00);
    check("lh_off1_err", 64'(e), 64'd0);
    do_load(0, 3'b010, 32'h100, 0, d, e, lat);
    check("lw_data", d, 64'hBEEF_0000);
    do_load(0, 3'b100, 32'h103, 0, d, e, lat);
    check("lbu_data", d, 64'h0000_00BE);

    // Word-crossing LW
    m32[32'h0FC] = 32'hAAAA_5555;
    m32[32'h100] = 32'h1234_CDEF;
    do_load(0, 3'b010, 32'h0FE, 0, d, e, lat);
`ifdef LD_MISALIGN_SPLIT_EN
    check("lw_split_data", d, 64'hCDEF_AAAA);
    check("lw_split_err", 64'(e), 64'd0);
    check("lw_split_beats", 64'(alog32.size()), 64'd2);
    check("lw_split_addr0", 64'(log_at(0, 0)), 64'h0FC);
    check("lw_split_addr1", 64'(log_at(0, 1)), 64'h100);
    check("split_extra_latency", 64'(lat - lat_al), 64'd2);
`else
    check("lw_cross_data", d, 64'd0);
    check("lw_cross_err", 64'(e), 64'd2);
    check("lw_cross_no_mem", 64'(seen32), 64'd0);
    check("lw_cross_latency", 64'(lat), 64'd0);
`endif

    // Illegal funct3: immediate error, no memory traffic
    do_load(0, 3'b111, 32'h100, 0, d, e, lat);
    check("ill111_err", 64'(e), 64'd1);
    check("ill111_data", d, 64'd0);
    check("ill111_latency", 64'(lat), 64'd0);
    check("ill111_no_mem", 64'(seen32), 64'd0);
    do_load(0, 3'b011, 32'h100, 0, d, e, lat);
    check("ld32_err", 64'(e), 64'd1);
    check("ld32_no_mem", 64'(seen32), 64'd0);

    // Back-pressure from WB for 5 cycles
    m32[32'h100] = 32'h80FF_1234;
    do_load(0, 3'b001, 32'h100, 5, d, e, lat);
    check("stall_lh_data", d, 64'h0000_1234);

    // Reset while waiting for the first word, then a late response
    mute32 = 1;
    bus32.req_func3 = 3'b010; bus32.req_addr = 32'h100; bus32.req_valid = 1;
    @(posedge clk); #1;
    bus32.req_valid = 0;
    @(posedge clk); #1;
    check("w0_mem_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    check("w0_req_ready", 64'(bus32.req_ready), 64'd0);
    rst = 1;
    @(posedge clk); #1;
    check("midrst_req_ready", 64'(bus32.req_ready), 64'd1);
    check("midrst_mem_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    check("midrst_mem_req_addr", 64'(bus32.mem_req_addr), 64'd0);
    check("midrst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("midrst_out_data", 64'(bus32.out_data), 64'd0);
    rst = 0;
    mute32 = 0;
    repeat (3) @(posedge clk); #1;
    check("late_rsp_out_valid", 64'(bus32.out_valid), 64'd0);
    check("late_rsp_req_ready", 64'(bus32.req_ready), 64'd1);
    check("late_rsp_mem_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    do_load(0, 3'b000, 32'h100, 0, d, e, lat);
    check("post_rst_lb", d, 64'h0000_0034);

    // XLEN=64 datapath
    m64[32'h200] = 64'h8877_6655_4433_2211;
    m64[32'h208] = 64'hFFEE_DDCC_BBAA_F1E2;
    do_load(1, 3'b011, 32'h200, 0, d, e, lat);
    check("ld64_data", d, 64'h8877_6655_4433_2211);
    do_load(1, 3'b010, 32'h204, 0, d, e, lat);
    check("lw64_data", d, 64'hFFFF_FFFF_8877_6655);
    check("lw64_err", 64'(e), 64'd0);

`ifdef LD_MISALIGN_SPLIT_EN
    bus64.mem_req_ready = 0;
    fork
      do_load(1, 3'b110, 32'h206, 0, d, e, lat);
      begin
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
          check("a0_stall_valid", 64'(bus64.mem_req_valid), 64'd1);
          check("a0_stall_addr", 64'(bus64.mem_req_addr), 64'h200);
          @(posedge clk); #2;
        end
        bus64.mem_req_ready = 1;
      end
    join
    check("lwu64_split_data", d, 64'h0000_0000_F1E2_8877);
    check("lwu64_split_err", 64'(e), 64'd0);
    check("lwu64_split_addr0", 64'(log_at(1, 0)), 64'h200);
    check("lwu64_split_addr1", 64'(log_at(1, 1)), 64'h208);
`else
    do_load(1, 3'b110, 32'h206, 0, d, e, lat);
    check("lwu64_cross_data", d, 64'd0);
    check("lwu64_cross_err", 64'(e), 64'd2);
    check("lwu64_cross_no_mem", 64'(seen64), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
